// File: rtl/counter_seg_display.sv
// rtl/counter_seg_display.sv - strobe-sampled counter with delta and 4-digit 7-segment scan
//
// Captures an upstream 8-bit counter value on sample_stb (unless frozen),
// keeps the step between the last two captures, and time-multiplexes
// {captured, delta} onto a 4-digit common-anode hex display.
//
// Ports:
//   clk_in     - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   value_in   - upstream value to sample
//   sample_stb - one-cycle capture request
//   freeze     - blocks captures, lights the decimal point on digit 2
//   captured   - most recently captured value
//   delta      - (captured - previous captured) mod 256
//   an         - active-low digit anodes, an[0] rightmost
//   seg        - active-low cathodes {g,f,e,d,c,b,a}
//   dp         - active-low decimal point
module counter_seg_display #(
  parameter int REFRESH_W = 17
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] value_in,
  input  logic       sample_stb,
  input  logic       freeze,
  output logic [7:0] captured,
  output logic [7:0] delta,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [REFRESH_W-1:0] REFRESH_ONE = {{(REFRESH_W-1){1'b0}}, 1'b1};

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           digit_idx;
  logic [3:0]           nibble;
  logic [3:0]           an_next;
  logic [6:0]           seg_next;
  logic                 dp_next;

  assign digit_idx = refresh_cnt[REFRESH_W-1 -: 2];

  // Capture path: delta uses the pre-edge captured value, so it is the step
  // from the previous capture (or from 0 for the first capture after reset).
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      captured <= 8'h00;
      delta    <= 8'h00;
    end else if (sample_stb && !freeze) begin
      captured <= value_in;
      delta    <= value_in - captured;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_ONE;
    end
  end

  // Digit select and hex decode. Everything here is computed from the
  // current (pre-edge) state and registered below, so anode and segment
  // patterns always change together.
  always_comb begin
    nibble  = delta[3:0];
    an_next = 4'b1110;
    case (digit_idx)
      2'd0: begin nibble = delta[3:0];    an_next = 4'b1110; end
      2'd1: begin nibble = delta[7:4];    an_next = 4'b1101; end
      2'd2: begin nibble = captured[3:0]; an_next = 4'b1011; end
      default: begin nibble = captured[7:4]; an_next = 4'b0111; end
    endcase
  end

  always_comb begin
    seg_next = 7'h7F;
    case (nibble)
      4'h0: seg_next = 7'h40;
      4'h1: seg_next = 7'h79;
      4'h2: seg_next = 7'h24;
      4'h3: seg_next = 7'h30;
      4'h4: seg_next = 7'h19;
      4'h5: seg_next = 7'h12;
      4'h6: seg_next = 7'h02;
      4'h7: seg_next = 7'h78;
      4'h8: seg_next = 7'h00;
      4'h9: seg_next = 7'h10;
      4'hA: seg_next = 7'h08;
      4'hB: seg_next = 7'h03;
      4'hC: seg_next = 7'h46;
      4'hD: seg_next = 7'h21;
      4'hE: seg_next = 7'h06;
      default: seg_next = 7'h0E;
    endcase
  end

  // Decimal point marks the frozen state, shown only on digit 2.
  assign dp_next = !((digit_idx == 2'd2) && freeze);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_counter_seg_display.sv
// tb/tb_counter_seg_display.sv - self-checking bench for counter_seg_display
module tb_counter_seg_display;

  logic       clk_in;
  logic       rst_n;
  logic [7:0] value_in;
  logic       sample_stb;
  logic       freeze;
  logic [7:0] captured;
  logic [7:0] delta;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  counter_seg_display #(.REFRESH_W(4)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .sample_stb (sample_stb),
    .freeze     (freeze),
    .captured   (captured),
    .delta      (delta),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: values as plain integers, time as edges since reset.
  int m_cap   = 0;
  int m_del   = 0;
  int m_edges = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic       stb;
    logic       frz;
    logic [7:0] val;
    logic [7:0] exp_cap;
    logic [7:0] exp_del;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock of stimulus and compare every output with the model.
  task automatic step(input logic stb, input logic frz, input logic [7:0] val);
    int idx;
    int nib;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    sample_stb = stb;
    freeze     = frz;
    value_in   = val;
    idx = (m_edges % 16) / 4;
    case (idx)
      0: nib = m_del % 16;
      1: nib = m_del / 16;
      2: nib = m_cap % 16;
      default: nib = m_cap / 16;
    endcase
    e_an  = 4'hF ^ (4'h1 << idx);
    e_seg = seg_tab[nib];
    e_dp  = !(idx == 2 && frz);
    if (stb && !frz) begin
      m_del = (int'(val) - m_cap + 256) % 256;
      m_cap = int'(val);
    end
    m_edges++;
    @(posedge clk_in);
    #1;
    check("captured", 32'(captured), 32'(m_cap));
    check("delta", 32'(delta), 32'(m_del));
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_captured"}, 32'(captured), 32'h00);
    check({tag, "_delta"}, 32'(delta), 32'h00);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_dp"}, 32'(dp), 32'h1);
  endtask

  // Reset pulsed between edges while a capture is being requested; the
  // request must be dropped and the first edge after release shows digit 0.
  task automatic reset_pulse(input logic stb, input logic [7:0] val);
    sample_stb = stb;
    value_in   = val;
    freeze     = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(posedge clk_in);
    #1 check_reset_vals("held_rst");
    rst_n = 1'b1;
    m_cap = 0;
    m_del = 0;
    m_edges = 0;
    step(1'b0, 1'b0, 8'h00);
    check("first_edge_an", 32'(an), 32'hE);
    check("first_edge_seg", 32'(seg), 32'h40);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h12, 8'h12, 8'h12};
    vecs[1]  = '{1'b0, 1'b0, 8'h77, 8'h12, 8'h12};
    vecs[2]  = '{1'b1, 1'b0, 8'h10, 8'h10, 8'hFE};
    vecs[3]  = '{1'b1, 1'b0, 8'h0B, 8'h0B, 8'hFB};
    vecs[4]  = '{1'b1, 1'b0, 8'hFE, 8'hFE, 8'hF3};
    vecs[5]  = '{1'b1, 1'b0, 8'h03, 8'h03, 8'h05};
    vecs[6]  = '{1'b1, 1'b1, 8'h55, 8'h03, 8'h05};
    vecs[7]  = '{1'b0, 1'b1, 8'h55, 8'h03, 8'h05};
    vecs[8]  = '{1'b0, 1'b0, 8'h55, 8'h03, 8'h05};
    vecs[9]  = '{1'b1, 1'b0, 8'h20, 8'h20, 8'h1D};
    vecs[10] = '{1'b1, 1'b0, 8'h22, 8'h22, 8'h02};
    vecs[11] = '{1'b1, 1'b0, 8'h24, 8'h24, 8'h02};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h24, 8'h02};

    rst_n      = 1'b0;
    sample_stb = 1'b1;
    freeze     = 1'b0;
    value_in   = 8'hAA;
    repeat (2) @(posedge clk_in);
    #1 check_reset_vals("por");

    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    check("por_first_an", 32'(an), 32'hE);
    check("por_first_seg", 32'(seg), 32'h40);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].stb, vecs[i].frz, vecs[i].val);
      check($sformatf("vec%0d_cap", i), 32'(captured), 32'(vecs[i].exp_cap));
      check($sformatf("vec%0d_del", i), 32'(delta), 32'(vecs[i].exp_del));
    end

    // Frozen for a full scan with strobes: nothing captured, dp only on digit 2.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'h55);
    check("freeze_cap", 32'(captured), 32'h24);

    // Known display content, two full scans.
    step(1'b1, 1'b0, 8'h6B);
    step(1'b1, 1'b0, 8'hA7);
    check("scan_cap", 32'(captured), 32'hA7);
    check("scan_del", 32'(delta), 32'h3C);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 8'h00);

    reset_pulse(1'b1, 8'h99);
    step(1'b1, 1'b0, 8'h12);
    check("post_rst_del", 32'(delta), 32'h12);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse(1'($urandom_range(0, 1)), 8'($urandom));
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom));
      end
    end

    reset_pulse(1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
